// File: rtl/fm_mod_pkg.sv
// Shared constants and FSM encoding for the stereo matrix sequencer.
package fm_mod_pkg;

  localparam int DEF_W          = 18;
  localparam int DEF_KW         = 4;
  localparam int DEF_PRE_SHIFT  = 3;
  localparam int DEF_POST_SHIFT = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult_su.sv
// Signed x unsigned shift-add multiplier, one gain bit per clock, LSB first.
// done is high during the cycle in which the final iteration is performed,
// so a controller can leave its multiply state on the same edge.
module seq_mult_su
  import fm_mod_pkg::*;
#(
  parameter int AW = DEF_W + 1 + DEF_PRE_SHIFT,
  parameter int BW = DEF_KW
)(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [AW-1:0]    a,
  input  logic        [BW-1:0]    b,
  output logic signed [AW+BW-1:0] prod,
  output logic                    done
);

  localparam int PW = AW + BW;
  localparam int CW = $clog2(BW + 1);

  logic signed [PW-1:0] mcand;
  logic        [BW-1:0] mult;
  logic        [CW-1:0] cnt;

  assign done = (cnt == CW'(1));

  // Load operands on start, then accumulate the shifted multiplicand per gain bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      mcand <= '0;
      mult  <= '0;
      cnt   <= '0;
      prod  <= '0;
    end else if (start) begin
      mcand <= PW'(a);
      mult  <= b;
      cnt   <= CW'(BW);
      prod  <= '0;
    end else if (cnt != '0) begin
      if (mult[0]) prod <= prod + mcand;
      mcand <= mcand <<< 1;
      mult  <= mult >> 1;
      cnt   <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/stereo_matrix_seq.sv
// Stereo L+R / L-R matrix with sequential gain multiply.
// Optional feature: define STEREO_MATRIX_SAT_EN to clamp results to the
// W-bit signed range and report clipping on sat_flag; otherwise results
// wrap to the low W bits and sat_flag stays 0.
//
// state  | meaning
// IDLE   | ready for a new sample pair (in_ready=1)
// MULT   | KW shift-add iterations in both channel multipliers
// DONE   | register results, pulse out_valid, return to IDLE
module stereo_matrix_seq
  import fm_mod_pkg::*;
#(
  parameter int W          = DEF_W,
  parameter int KW         = DEF_KW,
  parameter int PRE_SHIFT  = DEF_PRE_SHIFT,
  parameter int POST_SHIFT = DEF_POST_SHIFT
)(
  input  logic                clock,
  input  logic                reset,
  input  logic signed [W-1:0] left,
  input  logic signed [W-1:0] right,
  input  logic        [KW-1:0] ks,
  input  logic        [KW-1:0] kd,
  input  logic                in_valid,
  output logic                in_ready,
  output logic signed [W-1:0] out_lpr,
  output logic signed [W-1:0] out_lmr,
  output logic                out_valid,
  output logic                sat_flag
);

  localparam int AW = W + 1 + PRE_SHIFT;
  localparam int PW = AW + KW;

  state_t               state;
  logic                 start;
  logic                 lpr_last;
  logic                 lmr_last_unused;
  logic signed [W:0]    lr_sum;
  logic signed [W:0]    lr_dif;
  logic signed [AW-1:0] sum_pre;
  logic signed [AW-1:0] dif_pre;
  logic signed [PW-1:0] lpr_prod;
  logic signed [PW-1:0] lmr_prod;
  logic signed [PW-1:0] lpr_sh;
  logic signed [PW-1:0] lmr_sh;
  logic        [W-1:0]  lpr_res;
  logic        [W-1:0]  lmr_res;
  logic                 sat_any;

  // Full-precision sum and difference, pre-scaled before the multiply.
  always_comb begin
    lr_sum  = {left[W-1], left} + {right[W-1], right};
    lr_dif  = {left[W-1], left} - {right[W-1], right};
    sum_pre = AW'(lr_sum) <<< PRE_SHIFT;
    dif_pre = AW'(lr_dif) <<< PRE_SHIFT;
  end

  assign start = (state == S_IDLE) && in_valid && !reset;

  seq_mult_su #(.AW(AW), .BW(KW)) u_mult_lpr (
    .clock (clock),
    .reset (reset),
    .start (start),
    .a     (sum_pre),
    .b     (ks),
    .prod  (lpr_prod),
    .done  (lpr_last)
  );

  seq_mult_su #(.AW(AW), .BW(KW)) u_mult_lmr (
    .clock (clock),
    .reset (reset),
    .start (start),
    .a     (dif_pre),
    .b     (kd),
    .prod  (lmr_prod),
    .done  (lmr_last_unused)
  );

`ifdef STEREO_MATRIX_SAT_EN
  logic lpr_ovf;
  logic lmr_ovf;

  // Floor-scale the products and clamp to the W-bit signed range.
  always_comb begin
    lpr_sh  = lpr_prod >>> POST_SHIFT;
    lmr_sh  = lmr_prod >>> POST_SHIFT;
    lpr_ovf = (lpr_sh[PW-1:W-1] != {(PW-W+1){lpr_sh[PW-1]}});
    lmr_ovf = (lmr_sh[PW-1:W-1] != {(PW-W+1){lmr_sh[PW-1]}});
    lpr_res = lpr_ovf ? {lpr_sh[PW-1], {(W-1){~lpr_sh[PW-1]}}} : lpr_sh[W-1:0];
    lmr_res = lmr_ovf ? {lmr_sh[PW-1], {(W-1){~lmr_sh[PW-1]}}} : lmr_sh[W-1:0];
    sat_any = lpr_ovf | lmr_ovf;
  end
`else
  logic unused_hi;

  // Floor-scale the products and keep the low W bits (two's-complement wrap).
  always_comb begin
    lpr_sh    = lpr_prod >>> POST_SHIFT;
    lmr_sh    = lmr_prod >>> POST_SHIFT;
    lpr_res   = lpr_sh[W-1:0];
    lmr_res   = lmr_sh[W-1:0];
    sat_any   = 1'b0;
    unused_hi = ^{lpr_sh[PW-1:W], lmr_sh[PW-1:W]};
  end
`endif

  // Sequencer with registered handshake and result outputs; reset aborts any operation.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_lpr   <= '0;
      out_lmr   <= '0;
      sat_flag  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state    <= S_MULT;
            in_ready <= 1'b0;
          end
        end
        S_MULT: begin
          if (lpr_last) state <= S_DONE;
        end
        S_DONE: begin
          out_lpr   <= lpr_res;
          out_lmr   <= lmr_res;
          sat_flag  <= sat_any;
          out_valid <= 1'b1;
          state     <= S_IDLE;
          in_ready  <= 1'b1;
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/stereo_matrix_seq.md
STEREO_MATRIX_SEQ -- requirements
Module: stereo_matrix_seq

Interface
REQ-001 The block SHALL have parameter W, default 18, meaning the signed sample width of inputs and outputs.
REQ-002 The block SHALL have parameter KW, default 4, meaning the unsigned gain width and the number of multiply iterations.
REQ-003 The block SHALL have parameter PRE_SHIFT, default 3, meaning the left shift applied to the sum and difference before multiplication.
REQ-004 The block SHALL have parameter POST_SHIFT, default 5, meaning the arithmetic right shift applied to each product.
REQ-005 The block SHALL have port clock, input, width 1: rising-edge clock.
REQ-006 The block SHALL have port reset, input, width 1: reset, synchronous, active-high; clock clock.
REQ-007 The block SHALL have ports left and right, inputs, signed W: the stereo samples.
REQ-008 The block SHALL have ports ks and kd, inputs, unsigned KW: the sum gain and the difference gain.
REQ-009 The block SHALL have port in_valid, input, width 1, and port in_ready, output, width 1: the input handshake.
REQ-010 The block SHALL have ports out_lpr and out_lmr, outputs, signed W: the scaled L+R and L-R results.
REQ-011 The block SHALL have port out_valid, output, width 1: a one-cycle result strobe.
REQ-012 The block SHALL have port sat_flag, output, width 1: set when the last result was clipped.

Function
REQ-013 The FSM SHALL have the states IDLE, MULT and DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 A capture SHALL occur on an edge where in_valid=1 and in_ready=1; it registers left, right, ks and kd and moves the FSM to MULT.
REQ-015 Internally the block SHALL form sum=(left+right)<<<PRE_SHIFT and dif=(left-right)<<<PRE_SHIFT, each W+1+PRE_SHIFT bits wide, with no loss of bits.
REQ-016 In MULT, each channel SHALL perform one shift-add iteration per clock, LSB of the gain first, for exactly KW clocks; it then moves to DONE.
REQ-017 Each product (W+1+PRE_SHIFT+KW bits) SHALL be shifted right arithmetically by POST_SHIFT, giving floor rounding.
REQ-018 On the DONE edge, out_lpr, out_lmr and sat_flag SHALL be registered, out_valid SHALL be 1 for exactly one cycle, and the FSM SHALL move to IDLE.
REQ-019 Latency SHALL be KW+1 rising edges from the capture edge to the edge that asserts out_valid.
REQ-020 Throughput SHALL be one sample per KW+2 cycles.
REQ-021 out_lpr and out_lmr SHALL hold their last values between strobes.
REQ-022 Changes to the inputs after a capture SHALL NOT affect the operation in flight.
REQ-023 in_valid SHALL be ignored outside IDLE, and no input SHALL be queued.
REQ-024 A gain of 0 SHALL yield a result of 0; the gain SHALL NOT be sign-extended.

Reset
REQ-025 While reset=1, the FSM SHALL go to IDLE and all outputs SHALL be 0 except in_ready=1, from the next edge.
REQ-026 A reset during MULT or DONE SHALL abort the operation, and no out_valid SHALL follow.
REQ-027 If reset and in_valid are both 1 on the same edge, reset SHALL take priority and no capture SHALL occur.

Configuration
REQ-028 With STEREO_MATRIX_SAT_EN defined, each result SHALL be clamped to [-2^(W-1), 2^(W-1)-1], and sat_flag SHALL be 1 if either channel clamped.
REQ-029 Without STEREO_MATRIX_SAT_EN, each result SHALL be the low W bits of the shifted product (two's-complement wrap), and sat_flag SHALL be tied to 0.

Structure
REQ-030 Package fm_mod_pkg SHALL hold the FSM state encoding and the default W, KW, PRE_SHIFT and POST_SHIFT constants.
REQ-031 Sub-module seq_mult_su (signed x unsigned shift-add multiplier, parametrised widths, start/done pins) SHALL be instantiated twice, once for L+R and once for L-R; the FSM SHALL sit in the top level.

Verification
REQ-032 With defaults, left=100, right=50, ks=8, kd=4 -> out_lpr=300, out_lmr=50, with out_valid exactly 5 edges after capture.
REQ-033 left=-100, right=100, ks=3, kd=15 -> out_lpr=0, out_lmr=-750 (floor).
REQ-034 left=right=131071, ks=15 -> with the macro, out_lpr=131071 and sat_flag=1; without it, out_lpr=-65544 and sat_flag=0.
REQ-035 in_valid held at 1 continuously -> captures exactly every 6 cycles, in_ready=0 during MULT/DONE, and the left change during MULT is ignored.
REQ-036 Reset asserted on the 2nd MULT cycle -> next cycle IDLE, outputs 0, in_ready=1, and no out_valid pulse.
REQ-037 ks=0 and kd=0 with any samples -> out_lpr=0 and out_lmr=0, with out_valid still pulsed once.
